// File: rtl/alu_multicycle.sv
// Multi-cycle integer ALU: single-cycle logic/arith/shift ops plus iterative MULTU/DIVU, valid/ready on both sides.
// Optional feature macro ALU_DIV_EN builds the restoring divider; without it DIVU is reported as an illegal code.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hiOut,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC_MUL = 2'd1,
`ifdef ALU_DIV_EN
    EXEC_DIV = 2'd2,
`endif
    DONE     = 2'd3
  } state_t;

  state_t           state_r, next_s;
  logic             in_ready_r, out_valid_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] opd_r, hi_r, lo_r;
  logic             divz_r;
  logic [WIDTH-1:0] data_out_r, hi_out_r;
  logic             zero_r, ovf_r, err_r;

  logic             accept_s, is_mul_s, is_div_s, last_s;
  logic [WIDTH-1:0] sum_s, dif_s, res_s;
  logic             ovf_s, err_s, slt_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] step_hi_s, step_lo_s;

  assign accept_s = in_valid & in_ready_r;
  assign is_mul_s = (Signal == F_MULTU);
`ifdef ALU_DIV_EN
  assign is_div_s = (Signal == F_DIVU);
`else
  assign is_div_s = 1'b0;
`endif
  assign last_s = (cnt_r == CW'(WIDTH-1));

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign dataOut   = data_out_r;
  assign hiOut     = hi_out_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign err       = err_r;

  // Single-cycle result from the live operands, latched on the accept edge
  always_comb begin
    sum_s = dataA + dataB;
    dif_s = dataA - dataB;
    // Differing signs decide SLT directly, so an overflowing A-B never misleads it
    slt_s = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) ? dataA[WIDTH-1] : dif_s[WIDTH-1];
    res_s = {WIDTH{1'b0}};
    ovf_s = 1'b0;
    err_s = 1'b0;
    case (Signal)
      F_ADD: begin
        res_s = sum_s;
        ovf_s = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum_s[WIDTH-1] != dataA[WIDTH-1]);
      end
      F_SUB: begin
        res_s = dif_s;
        ovf_s = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (dif_s[WIDTH-1] != dataA[WIDTH-1]);
      end
      F_AND:   res_s = dataA & dataB;
      F_OR:    res_s = dataA | dataB;
      F_SLT:   res_s = {{(WIDTH-1){1'b0}}, slt_s};
      F_SRL:   res_s = dataA >> dataB[SHW-1:0];
      default: err_s = 1'b1;
    endcase
  end

`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rext_s, ddif_s;
  logic             ge_s;
  logic [WIDTH-1:0] div_hi_s, div_lo_s;

  // Restoring divide step; a set rext_s[WIDTH] already guarantees rext_s >= divisor
  always_comb begin
    rext_s   = {hi_r, lo_r[WIDTH-1]};
    ddif_s   = rext_s - {1'b0, opd_r};
    ge_s     = rext_s[WIDTH] | ~ddif_s[WIDTH];
    div_hi_s = ge_s ? ddif_s[WIDTH-1:0] : rext_s[WIDTH-1:0];
    div_lo_s = {lo_r[WIDTH-2:0], ge_s};
  end
`endif

  // Shift-add multiply step and per-state selection of the iteration result
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
`ifdef ALU_DIV_EN
    if (state_r == EXEC_DIV) begin
      step_hi_s = div_hi_s;
      step_lo_s = div_lo_s;
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end
`else
    step_hi_s = mul_sum_s[WIDTH:1];
    step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
`endif
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          next_s = IDLE;
        end else if (is_mul_s) begin
          next_s = EXEC_MUL;
`ifdef ALU_DIV_EN
        end else if (is_div_s) begin
          next_s = EXEC_DIV;
`endif
        end else begin
          next_s = DONE;
        end
      end
`ifdef ALU_DIV_EN
      EXEC_DIV,
`endif
      EXEC_MUL: begin
        if (last_s) next_s = DONE;
        else        next_s = state_r;
      end
      DONE: begin
        if (out_ready) next_s = IDLE;
        else           next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State and handshake registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      in_ready_r  <= (next_s == IDLE);
      out_valid_r <= (next_s == DONE);
    end
  end

  // Operand capture, iteration registers and result/flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= {CW{1'b0}};
      opd_r      <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
      divz_r     <= 1'b0;
      data_out_r <= {WIDTH{1'b0}};
      hi_out_r   <= {WIDTH{1'b0}};
      zero_r     <= 1'b0;
      ovf_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (is_mul_s || is_div_s)) begin
            opd_r  <= is_mul_s ? dataA : dataB;
            lo_r   <= is_mul_s ? dataB : dataA;
            hi_r   <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            divz_r <= is_div_s && (dataB == {WIDTH{1'b0}});
          end else if (accept_s) begin
            data_out_r <= res_s;
            hi_out_r   <= {WIDTH{1'b0}};
            zero_r     <= (res_s == {WIDTH{1'b0}});
            ovf_r      <= ovf_s;
            err_r      <= err_s;
          end
        end
`ifdef ALU_DIV_EN
        EXEC_DIV,
`endif
        EXEC_MUL: begin
          hi_r  <= step_hi_s;
          lo_r  <= step_lo_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            data_out_r <= step_lo_s;
            hi_out_r   <= step_hi_s;
            zero_r     <= (step_lo_s == {WIDTH{1'b0}});
            ovf_r      <= 1'b0;
            err_r      <= divz_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Table-driven self-checking bench for alu_multicycle (WIDTH=32) with a scoreboard queue of expected results.
module tb_alu_multicycle;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] dataA, dataB, dataOut, hiOut;
  logic [5:0]   Signal;
  logic         zero, ovf, err;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .Signal(Signal), .out_valid(out_valid),
    .out_ready(out_ready), .dataOut(dataOut), .hiOut(hiOut),
    .zero(zero), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [5:0]   sig;
    logic [W-1:0] a, b, lo, hi;
    logic         z, o, e;
    int           lat;
    int           hold;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t sb_q[$];
  vec_t vecs[16];

  function automatic vec_t mk(input string name, input logic [5:0] sig, input logic [W-1:0] a, b, lo, hi,
                              input logic z, o, e, input int lat, input int hold);
    vec_t v;
    v.name = name; v.sig = sig; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    v.z = z; v.o = o; v.e = e; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    vec_t         e;
    int           lat;
    logic         busy_ok, stable;
    logic [W-1:0] held;
    chk({v.name, " ready_before"}, {63'd0, in_ready}, 64'd1);
    Signal = v.sig; dataA = v.a; dataB = v.b;
    in_valid = 1'b1; out_ready = (v.hold == 0);
    step();
    sb_q.push_back(v);
    in_valid = 1'b0; dataA = $urandom; dataB = $urandom; Signal = 6'd37;
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = lat[0];
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
    chk({v.name, " busy"}, {63'd0, busy_ok}, 64'd1);
    e = sb_q.pop_front();
    chk({e.name, " dataOut"}, 64'(dataOut), 64'(e.lo));
    chk({e.name, " hiOut"}, 64'(hiOut), 64'(e.hi));
    chk({e.name, " flags z/o/e"}, {61'd0, zero, ovf, err}, {61'd0, e.z, e.o, e.e});
    if (v.hold > 0) begin
      held = dataOut; stable = 1'b1;
      repeat (v.hold) begin
        step();
        if (!out_valid || dataOut !== held) stable = 1'b0;
      end
      chk({v.name, " held"}, {63'd0, stable}, 64'd1);
      out_ready = 1'b1;
    end
    step();
    chk({v.name, " ready/valid after"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic seen_valid;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Signal = 6'd0; dataA = {W{1'b0}}; dataB = {W{1'b0}};

    vecs[0]  = mk("add_ovf",  6'd32, 32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1, 0);
    vecs[1]  = mk("sub_zero", 6'd34, 32'h5,        32'h5,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
    vecs[2]  = mk("slt_neg",  6'd42, 32'h80000000, 32'h1,        32'h1,        32'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    vecs[3]  = mk("slt_ovf",  6'd42, 32'h7FFFFFFF, 32'h80000000, 32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
    vecs[4]  = mk("and",      6'd36, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    vecs[5]  = mk("or",       6'd37, 32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    vecs[6]  = mk("srl_bp",   6'd2,  32'h000000F0, 32'h00000024, 32'h0000000F, 32'h0, 1'b0, 1'b0, 1'b0, 1, 5);
    vecs[7]  = mk("srl_31",   6'd2,  32'h80000000, 32'h0000001F, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0);
    vecs[8]  = mk("sub_ovf",  6'd34, 32'h80000000, 32'h1,        32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1, 0);
    vecs[9]  = mk("add_wrap", 6'd32, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
    vecs[10] = mk("mul_max",  6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33, 0);
    vecs[11] = mk("mul_16",   6'd25, 32'h12345678, 32'h10,       32'h23456780, 32'h1,  1'b0, 1'b0, 1'b0, 33, 0);
`ifdef ALU_DIV_EN
    vecs[12] = mk("div_100_7", 6'd27, 32'd100,      32'd7,        32'd14,       32'd2,  1'b0, 1'b0, 1'b0, 33, 0);
    vecs[13] = mk("div_by0",   6'd27, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,  1'b0, 1'b0, 1'b1, 33, 0);
    vecs[14] = mk("div_big",   6'd27, 32'hFFFFFFFF, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 33, 0);
`else
    vecs[12] = mk("div_off_a", 6'd27, 32'd100,      32'd7,        32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0);
    vecs[13] = mk("div_off_b", 6'd27, 32'd9,        32'd0,        32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0);
    vecs[14] = mk("div_off_c", 6'd27, 32'hFFFFFFFF, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0);
`endif
    vecs[15] = mk("illegal",  6'd0,  32'h12345678, 32'h9,        32'h0,        32'h0, 1'b1, 1'b0, 1'b1, 1, 0);

    repeat (2) step();
    chk("reset ready/valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("reset data", {dataOut, hiOut}, 64'd0);
    chk("reset flags", {61'd0, zero, ovf, err}, 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // Reset in the middle of a MULTU discards it
    Signal = 6'd25; dataA = 32'hFFFFFFFF; dataB = 32'hFFFFFFFF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    sb_q.push_back(vecs[10]);
    in_valid = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    chk("midrst ready/valid", {62'd0, in_ready, out_valid}, 64'd2);
    chk("midrst data", {dataOut, hiOut}, 64'd0);
    chk("midrst flags", {61'd0, zero, ovf, err}, 64'd0);
    sb_q.delete();
    step();
    step();
    reset = 1'b0;
    seen_valid = 1'b0;
    repeat (40) begin
      step();
      if (out_valid || !in_ready) seen_valid = 1'b1;
    end
    chk("midrst no_result", {63'd0, seen_valid}, 64'd0);
    run(mk("add_after_rst", 6'd32, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
